// File: rtl/rs232_tx_arbiter_pkg.sv
// Shared types for the two-requester RS-232 transmit arbiter: FSM states and requester indices.
package rs232_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StWaitDone
    } tx_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // With both FIFOs non-empty the round-robin preference wins, otherwise the lone non-empty one.
    function automatic logic pick_req(input logic empty0, input logic empty1, input logic rr);
        if (!empty0 && !empty1) begin
            return rr;
        end
        return empty0 ? REQ_DBG : REQ_CPU;
    endfunction

endpackage

// File: rtl/rs232_tx_arbiter_if.sv
// Producer/transmitter signal bundle of the RS-232 transmit arbiter.
interface rs232_tx_arbiter_if;
    logic       req0_w;
    logic [7:0] req0_d;
    logic       req0_full;
    logic       req1_w;
    logic [7:0] req1_d;
    logic       req1_full;
    logic [1:0] overflow;
    logic       rs232out_busy;
    logic       rs232out_w;
    logic [7:0] rs232out_d;
    logic       idle;

    modport master (
        output req0_w, req0_d, req1_w, req1_d, rs232out_busy,
        input  req0_full, req1_full, overflow, rs232out_w, rs232out_d, idle
    );

    modport slave (
        input  req0_w, req0_d, req1_w, req1_d, rs232out_busy,
        output req0_full, req1_full, overflow, rs232out_w, rs232out_d, idle
    );
endinterface

// File: rtl/rs232_byte_fifo.sv
// 8-bit synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module rs232_byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_d,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FullCount = Depth[DEPTH_LOG2:0];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]            mem_q [Depth];
    logic [7:0]            mem_d [Depth];
    logic                  do_push, do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_d;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count alone defines what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin sharing of one RS-232 transmitter between the CPU store path and the debug source.
module rs232_tx_arbiter
    import rs232_tx_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input logic               clk,
    input logic               rst,
    rs232_tx_arbiter_if.slave bus
);
    localparam int unsigned TimerW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TimerW-1:0] TimerInit = TimerW'(BUSY_TIMEOUT - 1);

    tx_state_e         state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              rr_q, rr_d;
    logic              w_q, w_d;
    logic [7:0]        d_q, d_d;
    logic [1:0]        overflow_q, overflow_d;

    logic       full0, empty0, pop0;
    logic       full1, empty1, pop1;
    logic [7:0] head0, head1;
    logic       pick;

    rs232_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo_cpu (
        .clk    (clk),
        .rst    (rst),
        .push   (bus.req0_w),
        .push_d (bus.req0_d),
        .pop    (pop0),
        .full   (full0),
        .empty  (empty0),
        .head   (head0)
    );

    rs232_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo_dbg (
        .clk    (clk),
        .rst    (rst),
        .push   (bus.req1_w),
        .push_d (bus.req1_d),
        .pop    (pop1),
        .full   (full1),
        .empty  (empty1),
        .head   (head1)
    );

    assign pick = pick_req(empty0, empty1, rr_q);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rr_d    = rr_q;
        w_d     = 1'b0;
        d_d     = d_q;
        pop0    = 1'b0;
        pop1    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!bus.rs232out_busy && (!empty0 || !empty1)) begin
                    pop0    = (pick == REQ_CPU);
                    pop1    = (pick == REQ_DBG);
                    w_d     = 1'b1;
                    d_d     = (pick == REQ_DBG) ? head1 : head0;
                    rr_d    = ~pick;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                timer_d = TimerInit;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                // A transmitter that never raises busy is released after the timeout.
                if (bus.rs232out_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StWaitDone: begin
                if (!bus.rs232out_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A push is dropped only when full and not relieved by a same-cycle pop.
    always_comb begin
        overflow_d    = 2'b00;
        overflow_d[0] = bus.req0_w & full0 & ~pop0;
        overflow_d[1] = bus.req1_w & full1 & ~pop1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            rr_q       <= REQ_CPU;
            w_q        <= 1'b0;
            d_q        <= 8'h00;
            overflow_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rr_q       <= rr_d;
            w_q        <= w_d;
            d_q        <= d_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.req0_full  = full0;
    assign bus.req1_full  = full1;
    assign bus.overflow   = overflow_q;
    assign bus.rs232out_w = w_q;
    assign bus.rs232out_d = d_q;
    assign bus.idle       = empty0 & empty1 & (state_q == StIdle);

endmodule
